bist_engine: RTL and testbench

Parametrised logic-BIST engine for one circuit-under-test (CUT) with a single scan chain. It generates pseudo-random functional stimuli and scan-in data from an internal LFSR. It sequences scan shift/capture over a programmable pattern count, compacts CUT responses in a MISR, and compares the final signature against a compile-time golden value. It sits between the chip-level pins and the CUT, replacing the hand-wired LFSR/controller/MISR/comparator cluster used so far.

---
 rtl/bist_engine.sv | 90 +++++++++
 tb/tb_bist_engine.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bist_engine.sv
// bist_engine: logic BIST (LFSR stimulus, scan sequencing, MISR compaction, golden compare); define BIST_SIG_DUMP_EN to expose the live MISR on signature
module bist_engine #(
  parameter int N_IN = 3,
  parameter int N_OUT = 2,
  parameter int LFSR_W = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01,
  parameter int MISR_W = 21,
  parameter logic [MISR_W-1:0] MISR_TAPS = 21'h140000,
  parameter logic [MISR_W-1:0] GOLDEN = '0,
  parameter int SCAN_LEN = 16,
  parameter int N_PATTERNS = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bist_start,
  input  logic [N_IN-1:0]   func_in,
  output logic [N_IN-1:0]   cut_in,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_out,
  input  logic [N_OUT-1:0]  cut_resp,
  output logic              bist_running,
  output logic              bist_end,
  output logic              pass_fail,
  output logic [MISR_W-1:0] signature
);
  localparam int BW = $clog2(SCAN_LEN + 1);
  localparam int PW = $clog2(N_PATTERNS + 1);
  typedef enum logic [2:0] {IDLE, INIT, SHIFT, CAPTURE, FLUSH, COMPARE, DONE} state_t;
  state_t state, state_nxt;
  logic start_q, start, last_bit, last_pat;
  logic [BW-1:0] bit_cnt;
  logic [PW-1:0] pat_cnt;
  logic [LFSR_W-1:0] lfsr;
  logic [MISR_W-1:0] misr, misr_nxt;
  assign start = bist_start & ~start_q;
  assign last_bit = bit_cnt == BW'(SCAN_LEN - 1);
  assign last_pat = pat_cnt == PW'(N_PATTERNS - 1);
  assign misr_nxt = {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? MISR_TAPS : '0) ^ MISR_W'({cut_resp, scan_out});
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? INIT : state;
      INIT:       state_nxt = SHIFT;
      SHIFT:      state_nxt = last_bit ? CAPTURE : SHIFT;
      CAPTURE:    state_nxt = last_pat ? FLUSH : SHIFT;
      FLUSH:      state_nxt = last_bit ? COMPARE : FLUSH;
      COMPARE:    state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    scan_en = state == SHIFT || state == FLUSH;
    scan_in = state == SHIFT && lfsr[LFSR_W-1];
    bist_running = state != IDLE && state != DONE;
    bist_end = state == DONE;
    cut_in = bist_running ? lfsr[N_IN-1:0] : func_in;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      start_q <= 1'b0;
      lfsr <= LFSR_SEED;
      misr <= '0;
      bit_cnt <= '0;
      pat_cnt <= '0;
      pass_fail <= 1'b0;
    end else begin
      start_q <= bist_start;
      if (state == INIT) begin
        lfsr <= LFSR_SEED;
        misr <= '0;
        bit_cnt <= '0;
        pat_cnt <= '0;
        pass_fail <= 1'b0;
      end else begin
        if (state == SHIFT || state == CAPTURE) lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        if (state inside {SHIFT, CAPTURE, FLUSH, COMPARE}) misr <= misr_nxt;
        if (scan_en) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        if (state == CAPTURE) pat_cnt <= pat_cnt + 1'b1;
        if (state == COMPARE) pass_fail <= misr_nxt == GOLDEN;
      end
    end
`ifdef BIST_SIG_DUMP_EN
  assign signature = misr;
`else
  assign signature = '0;
`endif
endmodule

// File: tb/tb_bist_engine.sv
// tb_bist_engine: default, stuck-at and small-config BIST runs against a cycle-level software model
module tb_bist_engine;
  function automatic logic [20:0] misr_step(input logic [20:0] m, input logic [2:0] d);
    return {m[19:0], 1'b0} ^ (m[20] ? 21'h140000 : 21'h0) ^ {18'h0, d};
  endfunction
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction
  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] l;
    l = 8'h01;
    for (int i = 0; i < n; i++) l = lfsr_step(l);
    return l;
  endfunction
  // whole run: np patterns of (sl shifts + capture), then sl flush cycles and the compare cycle
  function automatic logic [20:0] golden(input int np, input int sl, input bit stuck);
    logic [7:0] lf;
    logic [20:0] m;
    logic [31:0] ch, mask;
    lf = 8'h01; m = '0; ch = '0; mask = (32'h1 << sl) - 1;
    for (int p = 0; p <= np; p++)
      for (int b = 0; b <= sl; b++) begin
        m = misr_step(m, {ch[1] & lf[2], (ch[0] ^ lf[0]) | stuck, ch[sl-1]});
        if (b == sl) ch = (((ch << 1) | (ch >> (sl - 1))) & mask) ^ (ch[0] ? {29'h0, lf[2:0]} : 32'h0);
        else ch = ((ch << 1) | {31'h0, p < np && lf[7]}) & mask;
        if (p < np) lf = lfsr_step(lf);
      end
    return m;
  endfunction
  localparam logic [20:0] G_DEF = golden(64, 16, 1'b0);
  localparam logic [20:0] G_SMALL = golden(2, 4, 1'b0);
  localparam int RUN_LEN = 64 * 17 + 16 + 2;
  logic CLK, RST, bist_start;
  logic [2:0] func_in;
  logic [2:0] d_ci, f_ci, s_ci;
  logic d_se, d_si, d_so, d_run, d_end, d_pf;
  logic f_se, f_si, f_so, f_run, f_end, f_pf;
  logic s_se, s_si, s_so, s_run, s_end, s_pf;
  logic [1:0] d_resp, f_resp, s_resp;
  logic [20:0] d_sig, f_sig, s_sig;
  logic [15:0] ch_d;
  logic [3:0] ch_s;
  int n_cmp = 0, n_err = 0;
  bist_engine #(.GOLDEN(G_DEF)) u_d (
    .CLK(CLK), .RST(RST), .bist_start(bist_start), .func_in(func_in), .cut_in(d_ci),
    .scan_en(d_se), .scan_in(d_si), .scan_out(d_so), .cut_resp(d_resp),
    .bist_running(d_run), .bist_end(d_end), .pass_fail(d_pf), .signature(d_sig));
  bist_engine #(.GOLDEN(G_DEF)) u_f (
    .CLK(CLK), .RST(RST), .bist_start(bist_start), .func_in(func_in), .cut_in(f_ci),
    .scan_en(f_se), .scan_in(f_si), .scan_out(f_so), .cut_resp(f_resp),
    .bist_running(f_run), .bist_end(f_end), .pass_fail(f_pf), .signature(f_sig));
  bist_engine #(.SCAN_LEN(4), .N_PATTERNS(2), .GOLDEN(G_SMALL)) u_s (
    .CLK(CLK), .RST(RST), .bist_start(bist_start), .func_in(func_in), .cut_in(s_ci),
    .scan_en(s_se), .scan_in(s_si), .scan_out(s_so), .cut_resp(s_resp),
    .bist_running(s_run), .bist_end(s_end), .pass_fail(s_pf), .signature(s_sig));
  // CUT model: scan chain that shifts under scan_en and otherwise does a data-dependent capture
  always @(posedge CLK or negedge RST)
    if (!RST) ch_d <= '0;
    else if (d_se) ch_d <= {ch_d[14:0], d_si};
    else ch_d <= {ch_d[14:0], ch_d[15]} ^ (ch_d[0] ? {13'h0, d_ci} : 16'h0);
  always @(posedge CLK or negedge RST)
    if (!RST) ch_s <= '0;
    else if (s_se) ch_s <= {ch_s[2:0], s_si};
    else ch_s <= {ch_s[2:0], ch_s[3]} ^ (ch_s[0] ? {1'b0, s_ci} : 4'h0);
  assign d_so = ch_d[15];
  assign d_resp = {ch_d[1] & d_ci[2], ch_d[0] ^ d_ci[0]};
  assign f_so = d_so;
  assign f_resp = {d_resp[1], 1'b1};
  assign s_so = ch_s[3];
  assign s_resp = {ch_s[1] & s_ci[2], ch_s[0] ^ s_ci[0]};
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_scan_en"}, d_se, 0);
    chk({tag, "_scan_in"}, d_si, 0);
    chk({tag, "_running"}, d_run, 0);
    chk({tag, "_end"}, d_end, 0);
    chk({tag, "_pass_fail"}, d_pf, 0);
    chk({tag, "_signature"}, d_sig, 0);
    chk({tag, "_cut_in"}, d_ci, func_in);
    chk({tag, "_small_end"}, s_end, 0);
  endtask
  task automatic run(input bit hold, input int pulse_k, input int rst_k, output int len);
    int se_bad, s_len;
    logic [2:0] s_last;
    logic exp_se;
    se_bad = 0; s_len = -1; s_last = '0; len = -1;
    bist_start = 1'b1;
    for (int k = 0; k < RUN_LEN + 200; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (k == 0) chk("end_low_at_init", d_end, 0);
      if (k == rst_k) begin
        func_in = 3'b101;
        RST = 1'b0;
        #1;
        chk_reset("midrun_reset");
        break;
      end
      if (s_run) s_last = s_ci;
      if (s_end && s_len < 0) s_len = k;
      if (d_end) begin
        len = k;
        break;
      end
      exp_se = (k == 0 || k >= RUN_LEN - 1) ? 1'b0 : (k >= RUN_LEN - 17) ? 1'b1 : ((k - 1) % 17 != 16);
      if (d_se !== exp_se || d_run !== 1'b1) se_bad++;
      if (!hold && k == 1) bist_start = 1'b0;
      if (k == pulse_k) bist_start = 1'b1;
      if (k == pulse_k + 2) bist_start = 1'b0;
    end
    if (rst_k < 0) begin
      chk("run_len", len, RUN_LEN);
      chk("scan_en_running_pattern_errors", se_bad, 0);
      chk("faulty_end_same_edge", f_end, 1);
      chk("small_run_len", s_len, 16);
      chk("small_lfsr_10_steps", s_last, lfsr_after(10) & 8'h07);
    end
  endtask
  task automatic check_done();
    chk("pass_fail_good", d_pf, 1);
    chk("pass_fail_stuck", f_pf, 0);
    chk("pass_fail_small", s_pf, 1);
    chk("done_running_low", d_run, 0);
    chk("done_scan_en_low", d_se, 0);
`ifdef BIST_SIG_DUMP_EN
    chk("signature_default", d_sig, G_DEF);
    chk("signature_small", s_sig, G_SMALL);
`else
    chk("signature_tied_default", d_sig, 0);
    chk("signature_tied_small", s_sig, 0);
`endif
    func_in = 3'($urandom);
    #1;
    chk("done_cut_in_default", d_ci, func_in);
    chk("done_cut_in_small", s_ci, func_in);
  endtask
  initial begin
    int len;
    logic [20:0] sig1;
    RST = 1'b0;
    bist_start = 1'b0;
    func_in = 3'($urandom);
    repeat (3) @(negedge CLK);
    chk_reset("por");
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      func_in = 3'($urandom);
      #1;
      chk("idle_cut_in", d_ci, func_in);
    end
    @(negedge CLK);
    run(1'b1, -1, -1, len);
    check_done();
    sig1 = d_sig;
    repeat (20) @(negedge CLK);
    chk("held_start_no_restart_end", d_end, 1);
    chk("held_start_no_restart_running", d_run, 0);
    bist_start = 1'b0;
    repeat (2) @(negedge CLK);
    run(1'b0, int'($urandom_range(20, 1000)), -1, len);
    check_done();
    chk("restart_same_signature", d_sig, sig1);
    @(negedge CLK);
    run(1'b0, -1, 500, len);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("after_reset_idle_running", d_run, 0);
    run(1'b0, int'($urandom_range(20, 400)), -1, len);
    check_done();
    chk("post_reset_same_signature", d_sig, sig1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
